dcache_controller: RTL
======================

Name: dcache_controller

Overview:
- Direct-mapped, write-back data cache controller on the consumer side of the data_bus interface; main_memory is the producer.
- Serves 32-bit word loads and stores from the core pipeline. Hits complete combinationally.
- Misses trigger an optional dirty-line writeback (srp/srr), then a 128-bit line fill (ldp/ldr) from main memory.

Parameters:
- NSETS, 16, number of cache lines; power of two, ≥2.
- IDXW, $clog2(NSETS), index width (derived).
- TAGW, PHY_LEN-4-IDXW, tag width (derived; PHY_LEN=20).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  core access request; held stable with address/data until cpu_ready.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  PHY_LEN  byte address. [1:0] ignored, [3:2] word select, [4+IDXW-1:4] index, [19:4+IDXW] tag.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid when cpu_ready & ~cpu_we.
- cpu_ready  out  1  access completes this cycle (combinational).
- bus  data_bus.consumer  —  drives ldp, srp, addr[PHY_LEN-1:0], srData[MBLEN-1:0]; receives ldr, srr, ldData[MBLEN-1:0]; MBLEN=128.

Behaviour:
- Storage: per line valid, dirty, tag[TAGW], data[128]. Word w occupies data[32w+31:32w].
- Reset: state=IDLE; all valid=0, dirty=0; ldp=0, srp=0, addr=0, srData=0; cpu_ready=0. Data arrays need not be cleared.
- Reset mid-operation: ldp/srp drop at that same edge. The line being filled stays invalid.
- hit = cpu_req & valid[idx] & (tag[idx]==cpu_addr tag).
- State IDLE:
  - cpu_ready = hit; cpu_rdata = selected word of line idx (combinational).
  - Store hit: at the edge, write cpu_wdata into the selected word and set dirty[idx]=1.
  - Miss: latch idx/tag into miss registers.
    - valid & dirty victim: go WB; the next edge asserts srp=1, addr={victim tag, idx, 4'h0}, srData=line.
    - otherwise: go FILL; the next edge asserts ldp=1, addr={req tag, idx, 4'h0}.
  - cpu_req=0: no action, cpu_ready=0.
- State WB:
  - srp, addr and srData held stable until a cycle with srr=1.
  - At that edge: srp=0, dirty=0, go FILL_REQ.
- State FILL_REQ:
  - One cycle with ldp=0, srp=0, so the producer returns to idle between transactions.
  - Next edge: ldp=1, addr={req tag, idx, 4'h0}; go FILL.
- State FILL:
  - ldp and addr held until a cycle with ldr=1.
  - At that edge: data[idx]=ldData, tag[idx]=req tag, valid=1, dirty=0, ldp=0, addr=0, go IDLE.
  - The core's still-held request then hits in IDLE. A store hit writes then and sets dirty.
- Outside IDLE, cpu_ready=0 regardless of cpu_req.
- Bus handshake:
  - ldp and srp are registered and never high together.
  - Each request is dropped on the edge that samples ldr/srr=1, so it is never seen again by a producer back in IDLE.
  - ldr/srr arriving when not awaited (wrong state, or srr in FILL) are ignored.
- Latency against main_memory (request asserted at edge E, response seen after E+8):
  - clean miss detected in cycle 0 → cpu_ready in cycle 10.
  - dirty miss → cpu_ready in cycle 20.
  - hit → cycle 0.
- cpu_addr changing while not ready is a protocol violation; behaviour is undefined but must not corrupt lines other than idx.

Test Plan:
- Reset, then load 0x00040 (idx 4) → miss; ldp=1 with addr=0x00040 until ldr; line filled; cpu_ready in cycle 10; cpu_rdata = ROM word 0 of line 4.
- Store 0xDEADBEEF to 0x00044, then load 0x00044 → store ready same cycle (hit); load returns 0xDEADBEEF in 0 cycles; dirty[4]=1; no bus activity.
- Load 0x01040 (same idx, new tag) → srp with addr=0x00040, srData word1=0xDEADBEEF; then FILL_REQ gap; then ldp addr=0x01040; ready in cycle 20; memory line 0x00040 reads back 0xDEADBEEF later.
- Assert rst during FILL (4 cycles after ldp) → ldp=0 next edge; valid[idx]=0; a subsequent load to the same address misses and refills correctly.
- Inject spurious ldr=1 in IDLE and srr=1 during FILL → no state change, no line update, handshake completes normally.
- Back-to-back misses to idx 0..NSETS-1, then loads to all → every load hits; ldp/srp never simultaneously high; each held exactly until its ldr/srr.

Source files
------------

// File: rtl/dcache_controller_if.sv
// data_bus: line-granular request/response link between a cache (consumer) and main memory (producer)
interface data_bus #(
  parameter int PHY_LEN = 20,
  parameter int MBLEN = 128
);
  logic               ldp;
  logic               srp;
  logic               ldr;
  logic               srr;
  logic [PHY_LEN-1:0] addr;
  logic [MBLEN-1:0]   srData;
  logic [MBLEN-1:0]   ldData;
  modport consumer (output ldp, srp, addr, srData, input ldr, srr, ldData);
  modport producer (input ldp, srp, addr, srData, output ldr, srr, ldData);
endinterface

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back data cache with 128-bit lines refilled over data_bus
module dcache_controller #(
  parameter int NSETS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  data_bus.consumer   bus
);
  localparam int PHY_LEN = 20;
  localparam int IDXW = $clog2(NSETS);
  localparam int TAGW = PHY_LEN - 4 - IDXW;
  typedef enum logic [1:0] {IDLE, WB, FILL_REQ, FILL} state_t;
  state_t state, state_n;
  logic [NSETS-1:0] valid, dirty;
  logic [TAGW-1:0] tags [NSETS];
  logic [127:0] data [NSETS];
  logic [IDXW-1:0] idx, m_idx;
  logic [TAGW-1:0] tag, m_tag;
  logic [1:0] word;
  logic hit, unused_ok;
  assign idx = cpu_addr[4+IDXW-1:4];
  assign tag = cpu_addr[PHY_LEN-1:4+IDXW];
  assign word = cpu_addr[3:2];
  assign unused_ok = &{1'b0, cpu_addr[1:0]};
  assign hit = cpu_req && valid[idx] && (tags[idx] == tag);
  assign cpu_ready = (state == IDLE) && hit;
  assign cpu_rdata = data[idx][{word, 5'd0} +: 32];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = (cpu_req && !hit) ? ((valid[idx] && dirty[idx]) ? WB : FILL) : IDLE;
      WB:       state_n = bus.srr ? FILL_REQ : WB;
      FILL_REQ: state_n = FILL;
      FILL:     state_n = bus.ldr ? IDLE : FILL;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      bus.ldp <= 1'b0;
      bus.srp <= 1'b0;
      bus.addr <= '0;
      bus.srData <= '0;
      m_idx <= '0;
      m_tag <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (hit && cpu_we) begin
            dirty[idx] <= 1'b1;
          end else if (cpu_req && !hit) begin
            m_idx <= idx;
            m_tag <= tag;
            if (valid[idx] && dirty[idx]) begin
              bus.srp <= 1'b1;
              bus.addr <= {tags[idx], idx, 4'h0};
              bus.srData <= data[idx];
            end else begin
              bus.ldp <= 1'b1;
              bus.addr <= {tag, idx, 4'h0};
            end
          end
        end
        WB: begin
          if (bus.srr) begin
            bus.srp <= 1'b0;
            dirty[m_idx] <= 1'b0;
          end
        end
        FILL_REQ: begin
          bus.ldp <= 1'b1;
          bus.addr <= {m_tag, m_idx, 4'h0};
        end
        FILL: begin
          if (bus.ldr) begin
            valid[m_idx] <= 1'b1;
            dirty[m_idx] <= 1'b0;
            bus.ldp <= 1'b0;
            bus.addr <= '0;
          end
        end
        default: ;
      endcase
    end
  end
  // Line storage carries no reset; validity alone decides whether contents matter.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && hit && cpu_we) begin
      data[idx][{word, 5'd0} +: 32] <= cpu_wdata;
    end else if (!rst && state == FILL && bus.ldr) begin
      data[m_idx] <= bus.ldData;
      tags[m_idx] <= m_tag;
    end
  end
endmodule
